// File: rtl/cpu_phase_gen_if.sv
// Phase generator control/status bundle: run/stall/window inputs in, phase strobes out.
// Pure wiring, no latency of its own.
// The stall input is the only flow-control signal carried; SINGLE_STEP_EN adds step_mode/step.
interface cpu_phase_gen_if #(
  parameter int NUM_PHASES = 6,
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 16
);
  localparam int PW = $clog2(NUM_PHASES);

  logic                 run;
  logic                 stall;
  logic [NUM_CH*PW-1:0] ch_start;
  logic [NUM_CH*PW-1:0] ch_stop;
`ifdef SINGLE_STEP_EN
  logic                 step_mode;
  logic                 step;
`endif
  logic [NUM_PHASES-1:0] phase;
  logic [PW-1:0]         phase_idx;
  logic [NUM_CH-1:0]     ch_en;
  logic                  cyc_start;
  logic [CNT_W-1:0]      cyc_cnt;
  logic                  busy;

`ifdef SINGLE_STEP_EN
  modport master (
    output run, stall, ch_start, ch_stop, step_mode, step,
    input  phase, phase_idx, ch_en, cyc_start, cyc_cnt, busy
  );
  modport slave (
    input  run, stall, ch_start, ch_stop, step_mode, step,
    output phase, phase_idx, ch_en, cyc_start, cyc_cnt, busy
  );
`else
  modport master (
    output run, stall, ch_start, ch_stop,
    input  phase, phase_idx, ch_en, cyc_start, cyc_cnt, busy
  );
  modport slave (
    input  run, stall, ch_start, ch_stop,
    output phase, phase_idx, ch_en, cyc_start, cyc_cnt, busy
  );
`endif
endinterface

// File: rtl/cpu_phase_gen.sv
// Instruction-cycle phase generator: one-hot phase, per-channel window enables, cycle counter.
// All outputs registered on the falling clk edge; run start takes one edge; optional SINGLE_STEP_EN adds HOLD.
// stall freezes phase/enables/counter; a stop request waits for both the cycle boundary and stall release.
module cpu_phase_gen #(
  parameter int NUM_PHASES = 6,
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 16
) (
  input logic clk,
  input logic rst,
  cpu_phase_gen_if.slave bus
);
  localparam int PW = $clog2(NUM_PHASES);
  localparam logic [PW-1:0]         LAST = PW'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] PH0  = NUM_PHASES'(1);

`ifdef SINGLE_STEP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;
`endif

  state_t                state;
  logic [NUM_PHASES-1:0] phase;
  logic [PW-1:0]         phase_idx;
  logic [NUM_CH-1:0]     ch_en;
  logic                  cyc_start;
  logic [CNT_W-1:0]      cyc_cnt;
  logic                  busy;
  logic [NUM_CH*PW-1:0]  sh_start;
  logic [NUM_CH*PW-1:0]  sh_stop;

  logic [PW-1:0]     idx_next;
  logic [NUM_CH-1:0] en_first;
  logic [NUM_CH-1:0] en_next;

  // Window membership; out-of-range bounds disable the channel, start > stop wraps around.
  function automatic logic in_win(logic [PW-1:0] s, logic [PW-1:0] e, logic [PW-1:0] i);
    if (int'(s) >= NUM_PHASES || int'(e) >= NUM_PHASES) return 1'b0;
    if (s <= e) return (i >= s) && (i <= e);
    return (i >= s) || (i <= e);
  endfunction

  // Enables for the phase about to be entered: phase 0 uses the live inputs being captured.
  always_comb begin
    idx_next = phase_idx + PW'(1);
    en_first = '0;
    en_next  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      en_first[k] = in_win(bus.ch_start[k*PW +: PW], bus.ch_stop[k*PW +: PW], {PW{1'b0}});
      en_next[k]  = in_win(sh_start[k*PW +: PW], sh_stop[k*PW +: PW], idx_next);
    end
  end

  // Control FSM with registered outputs, all updates on the falling edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      phase_idx <= '0;
      ch_en     <= '0;
      cyc_start <= 1'b0;
      cyc_cnt   <= '0;
      busy      <= 1'b0;
      sh_start  <= '0;
      sh_stop   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.run) begin
            state     <= RUN;
            phase     <= PH0;
            phase_idx <= '0;
            ch_en     <= en_first;
            cyc_start <= 1'b1;
            busy      <= 1'b1;
            sh_start  <= bus.ch_start;
            sh_stop   <= bus.ch_stop;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            if (phase_idx == LAST) begin
              cyc_cnt <= cyc_cnt + CNT_W'(1);
              if (!bus.run) begin
                state     <= IDLE;
                phase     <= '0;
                phase_idx <= '0;
                ch_en     <= '0;
                cyc_start <= 1'b0;
                busy      <= 1'b0;
`ifdef SINGLE_STEP_EN
              end else if (bus.step_mode) begin
                state     <= HOLD;
                phase     <= '0;
                phase_idx <= '0;
                ch_en     <= '0;
                cyc_start <= 1'b0;
                busy      <= 1'b0;
`endif
              end else begin
                phase     <= PH0;
                phase_idx <= '0;
                ch_en     <= en_first;
                cyc_start <= 1'b1;
                sh_start  <= bus.ch_start;
                sh_stop   <= bus.ch_stop;
              end
            end else begin
              phase     <= phase << 1;
              phase_idx <= idx_next;
              ch_en     <= en_next;
              cyc_start <= 1'b0;
            end
          end
        end
`ifdef SINGLE_STEP_EN
        HOLD: begin
          if (!bus.run) begin
            state <= IDLE;
          end else if (bus.step) begin
            state     <= RUN;
            phase     <= PH0;
            phase_idx <= '0;
            ch_en     <= en_first;
            cyc_start <= 1'b1;
            busy      <= 1'b1;
            sh_start  <= bus.ch_start;
            sh_stop   <= bus.ch_stop;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          phase     <= '0;
          phase_idx <= '0;
          ch_en     <= '0;
          cyc_start <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase     = phase;
  assign bus.phase_idx = phase_idx;
  assign bus.ch_en     = ch_en;
  assign bus.cyc_start = cyc_start;
  assign bus.cyc_cnt   = cyc_cnt;
  assign bus.busy      = busy;
endmodule
